gendelay_rrreader: RTL and testbench
====================================

# gendelay_rrreader

Read end for two delay queues. The block pops words from two queue instances, arbitrates round-robin between them, and presents the merged stream on a single registered output with a valid/ack handshake. It sits between a pair of producer pipelines and one downstream consumer stage.

## Interface
Parameters:
- WIDTH, 8, data word width of both queues and the output.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- q0_oready  in  1  queue 0 "head valid next cycle" indication.
- q0_wdata  in  WIDTH  queue 0 head word; meaningful only while the queue-0 head is valid.
- q0_re  out  1  pop queue 0 head this cycle.
- q1_oready, q1_wdata, q1_re  same as the queue-0 ports, for queue 1.
- ovalid  out  1  odata/osrc hold a word.
- odata  out  WIDTH  output word.
- osrc  out  1  source queue of the current odata (0 or 1).
- oack  in  1  consumer accepts odata this cycle; ignored while ovalid=0.
- idle  out  1  high when ovalid=0 and neither head is valid.

## Operation
- avail0/avail1 registers: avail0 <= q0_oready and avail1 <= q1_oready every cycle. availN therefore equals "queue N head valid now", and q0_wdata/q1_wdata are sampled only when the matching availN=1.
- accept = ~ovalid | oack, so the output slot is free this cycle.
- Grant:
  - Exactly one availN=1 → grant N.
  - Both availN=1 → grant the source opposite to the last-served pointer `last`.
  - Neither availN=1 → no grant.
- qN_re = accept & grantN & ~rst. The path oack→qN_re is combinational. qN_re never depends combinationally on qN_oready.
- On a pop: odata <= qN_wdata, osrc <= N, ovalid <= 1, last <= N.
- If accept=1 and there is no grant: ovalid <= 0 when oack=1, otherwise ovalid is held.
- odata/osrc are held unchanged while ovalid=1 and oack=0.
- At most one pop per cycle in total.
- Reset values: ovalid=0, odata=0, osrc=0, avail0=avail1=0, last=1 (queue 0 wins the first tie), q0_re=q1_re=0, idle=1.
- Reset mid-operation: any word in the output register is discarded and no pop is issued in a reset cycle. Queues are reset alongside by the same system reset.

## Timing
- Latency from a head becoming valid to ovalid is 2 cycles:
  - Cycle t: oready=1.
  - Cycle t+1: availN=1, pop.
  - Cycle t+2: ovalid=1.
- With oack held high and both queues continuously non-empty, throughput is 1 word/cycle, alternating 0,1,0,1.
- After a pop in cycle t, availN in t+1 already reflects the refilled head, because oready is sampled after re took effect. No duplicate or skipped word is allowed.
- Backpressure: oack=0 while ovalid=1 forces qN_re=0 the same cycle.
- Simultaneous oack=1 and pop: the old word is consumed and the new word loads in the same edge, so there is no bubble.

## Structure
- Source-ID constants SRC_Q0=0 and SRC_Q1=1 belong in the shared queue header so that downstream demux logic uses the same encoding.
- Optional sub-module `rr_arb2`: a 2-way round-robin grant with inputs req[1:0], last, and en, and output grant[1:0]. Keep it purely combinational; `last` lives in the parent.
- The test bench instantiates two real delay queues (WIDTH=8) as sources.

## Test plan
- Reset → after one rst=1 cycle: ovalid=0, q0_re=q1_re=0, idle=1, osrc=0; hold for 3 cycles with idle queues.
- Push 0x11,0x22,0x33 into q0 only, oack=1 → odata sequence 0x11,0x22,0x33 on consecutive cycles, osrc=0, each word exactly once, ovalid drops after 0x33.
- Preload q0={0xA0,0xA1}, q1={0xB0,0xB1}, oack=1 → output order 0xA0,0xB0,0xA1,0xB1 (q0 wins the first tie), osrc=0,1,0,1.
- Backpressure: same preload, oack=0 for 5 cycles after the first word → odata stays 0xA0, q0_re=q1_re=0 throughout; releasing oack resumes with 0xB0, with no loss or duplication.
- Back-to-back saturation: 20 words per queue, random pushes, oack random at 50% → scoreboard per source confirms in-order delivery, no drops, never two re in one cycle, qN_re never high while availN=0.
- Reset mid-stream: assert rst while ovalid=1 (odata=0x22) → next cycle ovalid=0, last=1; after release with fresh pushes, the first tie goes to q0.

Source files
------------

// File: rtl/gendelay_rrreader_pkg.sv
// Shared definitions for the two-queue read end: source encoding,
// grant encoding and the round-robin pick rule.
package gendelay_rrreader_pkg;

  localparam int DEFAULT_WIDTH = 8;

  // Source-queue encoding carried on osrc; downstream demux uses the same values.
  localparam logic SRC_Q0 = 1'b0;
  localparam logic SRC_Q1 = 1'b1;

  // One-hot grant encoding, bit N = pop queue N.
  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_Q0   = 2'b01;
  localparam logic [1:0] GRANT_Q1   = 2'b10;

  // Two-way round-robin: a lone requester wins; on a tie the source
  // opposite to the last-served one wins.
  function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic last);
    logic [1:0] g;
    g = GRANT_NONE;
    case (req)
      2'b01:   g = GRANT_Q0;
      2'b10:   g = GRANT_Q1;
      2'b11:   g = (last == SRC_Q1) ? GRANT_Q0 : GRANT_Q1;
      default: g = GRANT_NONE;
    endcase
    return g;
  endfunction

  // Source id of a one-hot grant.
  function automatic logic grant_src(input logic [1:0] grant);
    return grant[1] ? SRC_Q1 : SRC_Q0;
  endfunction

endpackage

// File: rtl/gendelay_rrreader_rr_arb2.sv
// Purely combinational 2-way round-robin grant. The last-served pointer
// is owned by the parent; en gates every grant off.
module rr_arb2
  import gendelay_rrreader_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  input  logic       en,
  output logic [1:0] grant
);

  // Grant only when enabled; otherwise no queue is popped.
  always_comb begin
    grant = GRANT_NONE;
    if (en) begin
      grant = rr_pick(req, last);
    end
  end

endmodule

// File: rtl/gendelay_rrreader.sv
// Read end for two delay queues: pops heads round-robin and presents the
// merged stream on one registered output slot.
//
// Handshake: the output slot holds a word while ovalid=1; the word is
// consumed in any cycle where ovalid=1 and oack=1. The slot may be refilled
// from a queue in a cycle where it is empty or being consumed
// (accept = ~ovalid | oack), so oack feeds qN_re combinationally. qN_re
// depends only on the registered availN, never on qN_oready directly.
module gendelay_rrreader
  import gendelay_rrreader_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             q0_oready,
  input  logic [WIDTH-1:0] q0_wdata,
  output logic             q0_re,
  input  logic             q1_oready,
  input  logic [WIDTH-1:0] q1_wdata,
  output logic             q1_re,
  output logic             ovalid,
  output logic [WIDTH-1:0] odata,
  output logic             osrc,
  input  logic             oack,
  output logic             idle
);

  logic             avail0;
  logic             avail1;
  logic             last;
  logic             accept;
  logic             arb_en;
  logic [1:0]       grant;
  logic             pop;
  logic [WIDTH-1:0] pop_data;
  logic             pop_src;

  assign accept = ~ovalid | oack;
  assign arb_en = accept & ~rst;

  rr_arb2 u_arb (
    .req   ({avail1, avail0}),
    .last  (last),
    .en    (arb_en),
    .grant (grant)
  );

  assign q0_re    = grant[0];
  assign q1_re    = grant[1];
  assign pop      = |grant;
  assign pop_data = grant[1] ? q1_wdata : q0_wdata;
  assign pop_src  = grant_src(grant);
  assign idle     = ~ovalid & ~avail0 & ~avail1;

  // Register the "head valid next cycle" flags so availN means "head valid now".
  always_ff @(posedge clk) begin
    if (rst) begin
      avail0 <= 1'b0;
      avail1 <= 1'b0;
    end else begin
      avail0 <= q0_oready;
      avail1 <= q1_oready;
    end
  end

  // Output slot: load on a pop, drain on ack with no pop, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovalid <= 1'b0;
      odata  <= '0;
      osrc   <= SRC_Q0;
      last   <= SRC_Q1;
    end else if (pop) begin
      ovalid <= 1'b1;
      odata  <= pop_data;
      osrc   <= pop_src;
      last   <= pop_src;
    end else if (oack) begin
      ovalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gendelay_rrreader.sv
// Bench for gendelay_rrreader: two behavioural delay queues feed the DUT,
// a per-source expected queue checks delivery order, and a negedge monitor
// checks the pop rules every cycle.
module tb_gendelay_rrreader;

  logic       clk;
  logic       rst;
  logic       q0_oready, q1_oready;
  logic [7:0] q0_wdata, q1_wdata;
  logic       q0_re, q1_re;
  logic       ovalid;
  logic [7:0] odata;
  logic       osrc;
  logic       oack;
  logic       idle;

  int n_tests = 0;
  int n_fail  = 0;
  int acc_cnt = 0;

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  gendelay_rrreader #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .q0_oready (q0_oready),
    .q0_wdata  (q0_wdata),
    .q0_re     (q0_re),
    .q1_oready (q1_oready),
    .q1_wdata  (q1_wdata),
    .q1_re     (q1_re),
    .ovalid    (ovalid),
    .odata     (odata),
    .osrc      (osrc),
    .oack      (oack),
    .idle      (idle)
  );

  // ---------------- delay queue sources ----------------
  logic       push0, push1;
  logic [7:0] pdata0, pdata1;
  logic [7:0] mem0 [0:63];
  logic [7:0] mem1 [0:63];
  int wp0 = 0, rp0 = 0, wp1 = 0, rp1 = 0;

  // Head valid next cycle: occupancy after this cycle's push and pop.
  assign q0_oready = ((wp0 - rp0) + int'(push0) - int'(q0_re)) > 0;
  assign q1_oready = ((wp1 - rp1) + int'(push1) - int'(q1_re)) > 0;
  assign q0_wdata  = mem0[rp0[5:0]];
  assign q1_wdata  = mem1[rp1[5:0]];

  always @(posedge clk) begin
    if (rst) begin
      wp0 <= 0; rp0 <= 0; wp1 <= 0; rp1 <= 0;
    end else begin
      if (push0) begin mem0[wp0[5:0]] <= pdata0; wp0 <= wp0 + 1; end
      if (push1) begin mem1[wp1[5:0]] <= pdata1; wp1 <= wp1 + 1; end
      if (q0_re) rp0 <= rp0 + 1;
      if (q1_re) rp1 <= rp1 + 1;
    end
  end

  // ---------------- reference model state ----------------
  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];
  logic av_m0, av_m1, last_m;

  always @(posedge clk) begin
    if (rst) begin
      av_m0 <= 1'b0; av_m1 <= 1'b0; last_m <= 1'b1;
    end else begin
      av_m0 <= q0_oready;
      av_m1 <= q1_oready;
      if (q0_re) last_m <= 1'b0;
      else if (q1_re) last_m <= 1'b1;
    end
  end

  // ---------------- per-cycle monitor + scoreboard ----------------
  always @(negedge clk) begin
    logic [7:0] e;
    if (rst) begin
      n_tests++;
      if ((q0_re | q1_re) !== 1'b0) begin
        n_fail++; $display("FAIL re_in_reset: q0_re=%b q1_re=%b expected 0", q0_re, q1_re);
      end
    end else begin
      n_tests++;
      if (q0_re === 1'b1 && q1_re === 1'b1) begin
        n_fail++; $display("FAIL two_re: both re high at %0t", $time);
      end
      n_tests++;
      if ((q0_re === 1'b1 && !av_m0) || (q1_re === 1'b1 && !av_m1)) begin
        n_fail++; $display("FAIL re_no_avail: re=%b%b avail=%b%b", q1_re, q0_re, av_m1, av_m0);
      end
      n_tests++;
      if (ovalid === 1'b1 && oack === 1'b0 && (q0_re | q1_re) !== 1'b0) begin
        n_fail++; $display("FAIL bp_re: re=%b%b while stalled", q1_re, q0_re);
      end
      n_tests++;
      if ((!ovalid || oack) && (av_m0 || av_m1) && (q0_re | q1_re) !== 1'b1) begin
        n_fail++; $display("FAIL missed_pop: re=%b%b avail=%b%b expected a pop", q1_re, q0_re, av_m1, av_m0);
      end
      if (av_m0 && av_m1 && (q0_re | q1_re) === 1'b1) begin
        n_tests++;
        if (q1_re !== !last_m) begin
          n_fail++; $display("FAIL rr_tie: q1_re=%b expected %b", q1_re, !last_m);
        end
      end
      n_tests++;
      if (idle !== (!ovalid && !av_m0 && !av_m1)) begin
        n_fail++; $display("FAIL idle: got %b expected %b", idle, (!ovalid && !av_m0 && !av_m1));
      end
      if (ovalid === 1'b1 && oack === 1'b1) begin
        acc_cnt++;
        n_tests++;
        if (osrc === 1'b0) begin
          if (exp_q0.size() == 0) begin
            n_fail++; $display("FAIL sb_q0: got %h with nothing expected", odata);
          end else begin
            e = exp_q0.pop_front();
            if (odata !== e) begin n_fail++; $display("FAIL sb_q0: got %h expected %h", odata, e); end
          end
        end else begin
          if (exp_q1.size() == 0) begin
            n_fail++; $display("FAIL sb_q1: got %h with nothing expected", odata);
          end else begin
            e = exp_q1.pop_front();
            if (odata !== e) begin n_fail++; $display("FAIL sb_q1: got %h expected %h", odata, e); end
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; push0 = 1'b0; push1 = 1'b0; oack = 1'b0;
    exp_q0.delete(); exp_q1.delete();
    tick();
    rst = 1'b0;
  endtask

  task automatic drive_push(input logic p0, input logic [7:0] d0, input logic p1, input logic [7:0] d1);
    push0 = p0; pdata0 = d0; push1 = p1; pdata1 = d1;
    if (p0) exp_q0.push_back(d0);
    if (p1) exp_q1.push_back(d1);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; push0 = 1'b0; push1 = 1'b0; pdata0 = '0; pdata1 = '0; oack = 1'b0;
    tick();
    n_tests++;
    if (ovalid !== 1'b0 || q0_re !== 1'b0 || q1_re !== 1'b0 || idle !== 1'b1 || osrc !== 1'b0 || odata !== 8'h00) begin
      n_fail++;
      $display("FAIL reset: ovalid=%b re=%b%b idle=%b osrc=%b odata=%h expected 0 00 1 0 00",
               ovalid, q1_re, q0_re, idle, osrc, odata);
    end
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_tests++;
      if (ovalid !== 1'b0 || idle !== 1'b1 || q0_re !== 1'b0 || q1_re !== 1'b0) begin
        n_fail++; $display("FAIL reset_hold: ovalid=%b idle=%b re=%b%b expected 0 1 00", ovalid, idle, q1_re, q0_re);
      end
    end
  endtask

  task automatic test_q0_only();
    logic [7:0] w [0:2];
    w[0] = 8'h11; w[1] = 8'h22; w[2] = 8'h33;
    do_reset();
    for (int k = 0; k < 7; k++) begin
      oack = 1'b1;
      drive_push(k < 3, (k < 3) ? w[k] : 8'h00, 1'b0, 8'h00);
      n_tests++;
      if (ovalid !== (k >= 2 && k <= 4)) begin
        n_fail++; $display("FAIL q0_only_valid: cycle %0d got %b expected %b", k, ovalid, (k >= 2 && k <= 4));
      end
      if (k >= 2 && k <= 4) begin
        n_tests++;
        if (odata !== w[k-2] || osrc !== 1'b0) begin
          n_fail++; $display("FAIL q0_only_data: cycle %0d got %h/%b expected %h/0", k, odata, osrc, w[k-2]);
        end
      end
      tick();
    end
    push0 = 1'b0;
  endtask

  task automatic test_tie();
    logic [7:0] ed [0:3];
    logic       es [0:3];
    ed[0] = 8'hA0; ed[1] = 8'hB0; ed[2] = 8'hA1; ed[3] = 8'hB1;
    es[0] = 1'b0;  es[1] = 1'b1;  es[2] = 1'b0;  es[3] = 1'b1;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      oack = 1'b1;
      drive_push(k < 2, (k == 0) ? 8'hA0 : 8'hA1, k < 2, (k == 0) ? 8'hB0 : 8'hB1);
      n_tests++;
      if (ovalid !== (k >= 2 && k <= 5)) begin
        n_fail++; $display("FAIL tie_valid: cycle %0d got %b expected %b", k, ovalid, (k >= 2 && k <= 5));
      end
      if (k >= 2 && k <= 5) begin
        n_tests++;
        if (odata !== ed[k-2] || osrc !== es[k-2]) begin
          n_fail++; $display("FAIL tie_order: cycle %0d got %h/%b expected %h/%b", k, odata, osrc, ed[k-2], es[k-2]);
        end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] ed [0:8];
    logic       es [0:8];
    for (int i = 0; i < 6; i++) begin ed[i] = 8'hA0; es[i] = 1'b0; end
    ed[6] = 8'hB0; es[6] = 1'b1;
    ed[7] = 8'hA1; es[7] = 1'b0;
    ed[8] = 8'hB1; es[8] = 1'b1;
    do_reset();
    for (int k = 0; k < 12; k++) begin
      oack = !(k >= 2 && k <= 6);
      drive_push(k < 2, (k == 0) ? 8'hA0 : 8'hA1, k < 2, (k == 0) ? 8'hB0 : 8'hB1);
      n_tests++;
      if (ovalid !== (k >= 2 && k <= 10)) begin
        n_fail++; $display("FAIL bp_valid: cycle %0d got %b expected %b", k, ovalid, (k >= 2 && k <= 10));
      end
      if (k >= 2 && k <= 10) begin
        n_tests++;
        if (odata !== ed[k-2] || osrc !== es[k-2]) begin
          n_fail++; $display("FAIL bp_data: cycle %0d got %h/%b expected %h/%b", k, odata, osrc, ed[k-2], es[k-2]);
        end
      end
      #1;
      if (k >= 2 && k <= 6) begin
        n_tests++;
        if (q0_re !== 1'b0 || q1_re !== 1'b0) begin
          n_fail++; $display("FAIL bp_stall_re: cycle %0d re=%b%b expected 00", k, q1_re, q0_re);
        end
      end
      tick();
    end
  endtask

  task automatic test_throughput();
    logic [7:0] w0 [0:5];
    logic [7:0] w1 [0:5];
    for (int i = 0; i < 6; i++) begin
      w0[i] = 8'(8'h40 + i);
      w1[i] = 8'(8'h80 + i);
    end
    do_reset();
    for (int k = 0; k < 15; k++) begin
      oack = 1'b1;
      drive_push(k < 6, (k < 6) ? w0[k] : 8'h00, k < 6, (k < 6) ? w1[k] : 8'h00);
      n_tests++;
      if (ovalid !== (k >= 2 && k <= 13)) begin
        n_fail++; $display("FAIL tput_valid: cycle %0d got %b expected %b", k, ovalid, (k >= 2 && k <= 13));
      end
      if (k >= 2 && k <= 13) begin
        n_tests++;
        if (osrc !== ((k - 2) % 2 == 1) ||
            odata !== (((k - 2) % 2 == 0) ? w0[(k-2)/2] : w1[(k-2)/2])) begin
          n_fail++;
          $display("FAIL tput_order: cycle %0d got %h/%b expected %h/%b", k, odata, osrc,
                   (((k - 2) % 2 == 0) ? w0[(k-2)/2] : w1[(k-2)/2]), ((k - 2) % 2 == 1));
        end
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] w0 [0:19];
    logic [7:0] w1 [0:19];
    int s0, s1, start, cyc;
    logic p0, p1;
    for (int i = 0; i < 20; i++) begin
      w0[i] = 8'($urandom_range(0, 255));
      w1[i] = 8'($urandom_range(0, 255));
    end
    do_reset();
    s0 = 0; s1 = 0; start = acc_cnt; cyc = 0;
    while ((acc_cnt - start) < 40 && cyc < 800) begin
      p0 = (s0 < 20) && ($urandom_range(0, 3) != 0);
      p1 = (s1 < 20) && ($urandom_range(0, 3) != 0);
      drive_push(p0, p0 ? w0[s0] : 8'h00, p1, p1 ? w1[s1] : 8'h00);
      if (p0) s0++;
      if (p1) s1++;
      oack = ($urandom_range(0, 1) == 1);
      tick();
      cyc++;
    end
    push0 = 1'b0; push1 = 1'b0; oack = 1'b0;
    n_tests++;
    if ((acc_cnt - start) != 40) begin
      n_fail++; $display("FAIL b2b_count: delivered %0d expected 40 within budget", acc_cnt - start);
    end
    n_tests++;
    if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
      n_fail++; $display("FAIL b2b_leftover: q0 %0d q1 %0d words undelivered expected 0", exp_q0.size(), exp_q1.size());
    end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      oack = 1'b1;
      drive_push(1'b1, 8'(8'h11 * (k + 1)), 1'b0, 8'h00);
      tick();
    end
    push0 = 1'b0;
    n_tests++;
    if (ovalid !== 1'b1 || odata !== 8'h22) begin
      n_fail++; $display("FAIL mid_pre: ovalid=%b odata=%h expected 1 22", ovalid, odata);
    end
    rst = 1'b1; oack = 1'b0;
    exp_q0.delete(); exp_q1.delete();
    #1;
    n_tests++;
    if (q0_re !== 1'b0 || q1_re !== 1'b0) begin
      n_fail++; $display("FAIL mid_re: re=%b%b expected 00 during reset", q1_re, q0_re);
    end
    tick();
    n_tests++;
    if (ovalid !== 1'b0 || idle !== 1'b1 || osrc !== 1'b0) begin
      n_fail++; $display("FAIL mid_post: ovalid=%b idle=%b osrc=%b expected 0 1 0", ovalid, idle, osrc);
    end
    rst = 1'b0;
    for (int j = 0; j < 7; j++) begin
      oack = 1'b1;
      drive_push(j < 2, (j == 0) ? 8'hC0 : 8'hC1, j < 2, (j == 0) ? 8'hD0 : 8'hD1);
      if (j == 2) begin
        n_tests++;
        if (ovalid !== 1'b1 || odata !== 8'hC0 || osrc !== 1'b0) begin
          n_fail++; $display("FAIL mid_first_tie: got %b/%h/%b expected 1/c0/0", ovalid, odata, osrc);
        end
      end
      if (j == 3) begin
        n_tests++;
        if (ovalid !== 1'b1 || odata !== 8'hD0 || osrc !== 1'b1) begin
          n_fail++; $display("FAIL mid_second: got %b/%h/%b expected 1/d0/1", ovalid, odata, osrc);
        end
      end
      tick();
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_q0_only();
    test_tie();
    test_backpressure();
    test_throughput();
    test_back_to_back();
    test_reset_midstream();
    do_reset();
    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
